mem_read_arbiter: RTL

- Merges AXI-style read requests from the instruction cache, data cache and instruction stream buffer onto the single memory read port.
- Sits directly downstream of the stream buffer's memory interface. The stream buffer is master 2.
- Grants one burst at a time using round-robin. Drives ARID with the master index, routes each R beat back to its owner, and checks the returned ID and burst length.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_grant.sv | 30 +++
 rtl/mem_read_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam int MASTER_ICACHE = 0;
    localparam int MASTER_DCACHE = 1;
    localparam int MASTER_SB     = 2;

    localparam int ID_WIDTH = 4;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: scans req from ptr upward (mod N); any
// request under mask takes precedence over unmasked requests.
module rr_grant #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [PTR_W-1:0] grant,
    output logic             any
);

    logic [N-1:0] cand;
    int           idx;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        grant = '0;
        any   = |req;
        cand  = ((req & mask) != '0) ? (req & mask) : req;
        idx   = 0;
        // Walk from the farthest offset back to ptr so the nearest candidate is written last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (cand[idx]) grant = idx[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter merging icache, dcache and stream-buffer bursts onto one
// memory read port. Define MEM_ARB_DEMAND_PRIO_EN to give masters 0/1 strict priority over master 2.
module mem_read_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  m_arlen,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS-1:0]            m_arready,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic                              m_rlast,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    output logic [ADDR_WIDTH-1:0]             mem_araddr,
    output logic [LEN_WIDTH-1:0]              mem_arlen,
    output logic [3:0]                        mem_arid,
    output logic                              mem_arvalid,
    input  logic                              mem_arready,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic [3:0]                        mem_rid,
    input  logic                              mem_rlast,
    input  logic                              mem_rvalid,
    output logic                              mem_rready,
    output logic                              err_rid,
    output logic                              err_len
);

    import mem_arb_pkg::*;

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    state_t                 state;
    state_t                 state_n;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant;
    logic [PTR_W-1:0]       pick;
    logic                   pick_any;
    logic [NUM_MASTERS-1:0] prio_mask;
    logic [LEN_WIDTH:0]     beat_cnt;
    logic [ADDR_WIDTH-1:0]  ar_addr;
    logic [LEN_WIDTH-1:0]   ar_len;
    logic [ID_WIDTH-1:0]    ar_id;
    logic                   accept;
    logic                   beat_hs;
    logic                   len_ok;

`ifdef MEM_ARB_DEMAND_PRIO_EN
    always_comb begin
        prio_mask                = '0;
        prio_mask[MASTER_ICACHE] = 1'b1;
        prio_mask[MASTER_DCACHE] = 1'b1;
    end
`else
    assign prio_mask = '0;
`endif

    rr_grant #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .req   (m_arvalid),
        .ptr   (rr_ptr),
        .mask  (prio_mask),
        .grant (pick),
        .any   (pick_any)
    );

    // Accept is suppressed during reset so no master sees a pulse that the FSM then forgets.
    assign accept  = (state == IDLE) && pick_any && !rst;
    assign beat_hs = (state == DATA) && mem_rvalid && m_rready[grant];
    assign len_ok  = (mem_rlast == (beat_cnt == {1'b0, ar_len}));

    assign mem_araddr  = ar_addr;
    assign mem_arlen   = ar_len;
    assign mem_arid    = ar_id;
    assign mem_arvalid = (state == ADDR);
    assign m_rdata     = mem_rdata;
    assign m_rlast     = mem_rlast;

    always_comb begin
        state_n    = state;
        m_arready  = '0;
        m_rvalid   = '0;
        mem_rready = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    m_arready[pick] = 1'b1;
                    state_n         = ADDR;
                end
            end
            ADDR: begin
                if (mem_arready) state_n = DATA;
            end
            DATA: begin
                mem_rready      = m_rready[grant];
                m_rvalid[grant] = mem_rvalid;
                if (beat_hs && mem_rlast) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every assignment samples pre-edge values regardless of order.
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            beat_cnt <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_id    <= '0;
            err_rid  <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ar_addr <= m_araddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                        ar_len  <= m_arlen[int'(pick)*LEN_WIDTH +: LEN_WIDTH];
                        grant   <= pick;
                        ar_id   <= ID_WIDTH'(pick);
                    end
                end
                ADDR: begin
                    if (mem_arready) beat_cnt <= '0;
                end
                DATA: begin
                    if (beat_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (mem_rid != ar_id) err_rid <= 1'b1;
                        if (!len_ok) err_len <= 1'b1;
                        // The master just served drops to lowest priority.
                        if (mem_rlast)
                            rr_ptr <= (grant == PTR_W'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
